// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request
// at a time and loads the IF/ID pipeline registers. An EX-stage redirect
// overrides stalls and cancels any fetch still in flight.
//
// state | meaning
// ------+----------------------------------------------------------
// REQ   | presenting imem_req_addr=pc, waiting for imem_req_ready
// WAIT  | request accepted, waiting for imem_resp_valid
// HOLD  | response captured while ID stalled; waiting for stall to drop
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_take_branch_in,
  input  logic [31:0] ex_target_PC_in,
  input  logic        stall_in,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic [31:0] if_id_IR,
  output logic        if_id_valid_inst
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] hold_data;
  logic        discard;

  logic        req_fire;
  logic        resp_live;
  logic        deliver;
  logic [31:0] deliver_data;
  logic [31:0] target_aligned;

  // Masking (rather than slicing) keeps every target bit in use.
  assign target_aligned = ex_target_PC_in & 32'hFFFF_FFFC;
  assign req_fire       = (state == S_REQ) && imem_req_ready;
  // A response only counts in WAIT, and not when it belongs to a cancelled fetch.
  assign resp_live      = (state == S_WAIT) && imem_resp_valid && !discard;
  assign deliver        = !ex_take_branch_in && !stall_in &&
                          (resp_live || (state == S_HOLD));
  assign deliver_data   = (state == S_HOLD) ? hold_data : imem_resp_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  // Next-state logic; redirect wins over stall in WAIT and HOLD
  always_comb begin
    state_next = state;
    case (state)
      S_REQ: begin
        if (req_fire) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (ex_take_branch_in || discard || !stall_in) state_next = S_REQ;
          else                                           state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ex_take_branch_in || !stall_in) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  // Request channel outputs; the address is just the PC, so it is stable while waiting
  always_comb begin
    imem_req_valid = (state == S_REQ);
    imem_req_addr  = pc;
  end

  // PC, discard flag and hold buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      discard   <= 1'b0;
      hold_data <= 32'h0;
    end else begin
      if (ex_take_branch_in) pc <= target_aligned;
      else if (deliver)      pc <= pc + 32'd4;

      // At most one response can be in flight, so a single flag suffices
      // even for back-to-back redirects.
      if (state == S_WAIT) begin
        if (imem_resp_valid)        discard <= 1'b0;
        else if (ex_take_branch_in) discard <= 1'b1;
      end else if (req_fire && ex_take_branch_in) begin
        discard <= 1'b1;
      end

      if (ex_take_branch_in)
        hold_data <= 32'h0;
      else if (resp_live && stall_in)
        hold_data <= imem_resp_data;
    end
  end

  // IF/ID pipeline registers: redirect flushes, stall holds, otherwise load or bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_PC         <= 32'h0;
      if_id_NPC        <= 32'h0;
      if_id_IR         <= NOP_INST;
      if_id_valid_inst <= 1'b0;
    end else if (ex_take_branch_in) begin
      if_id_IR         <= NOP_INST;
      if_id_valid_inst <= 1'b0;
    end else if (!stall_in) begin
      if (deliver) begin
        if_id_PC         <= pc;
        if_id_NPC        <= pc + 32'd4;
        if_id_IR         <= deliver_data;
        if_id_valid_inst <= 1'b1;
      end else begin
        if_id_IR         <= NOP_INST;
        if_id_valid_inst <= 1'b0;
      end
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV32 pipeline; drives the IF/ID pipeline registers.
- Owns the PC, issues single-outstanding requests to instruction memory via a valid/ready request channel and a valid-only response channel.
- Consumes the EX-stage branch outcome (take_branch, target PC) to redirect; honours the hazard-unit stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, IR value driven when if_id_valid_inst=0 (addi x0,x0,0).

Ports:
- clk  in  1  system clock.
- rst  in  1  async, active-high reset.
- ex_take_branch_in  in  1  redirect request from EX (already qualified by valid_inst/flash).
- ex_target_PC_in  in  32  redirect target.
- stall_in  in  1  ID cannot accept; IF/ID registers must hold.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address, bits[1:0]=0.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_resp_valid  in  1  instruction data valid; at earliest one cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- if_id_PC  out  32  PC of the instruction in IF/ID.
- if_id_NPC  out  32  if_id_PC+4.
- if_id_IR  out  32  instruction word.
- if_id_valid_inst  out  1  IF/ID holds a real instruction.

Behaviour:
- One clock, async active-high reset: PC=RESET_PC, state=REQ, discard=0, hold buffer empty, if_id_valid_inst=0, if_id_IR=NOP_INST, if_id_PC=0, if_id_NPC=0.
- FSM states REQ, WAIT, HOLD; at most one request outstanding.
- REQ: imem_req_valid=1, imem_req_addr=PC. On req_valid & req_ready -> WAIT. Address stays stable while waiting, except on redirect.
- WAIT: imem_req_valid=0. On resp_valid:
  - discard=1: drop data, clear discard -> REQ.
  - stall_in=0: load IF/ID (PC, PC+4, data, valid=1), PC<=PC+4 -> REQ.
  - stall_in=1: capture data into hold buffer -> HOLD.
- HOLD: imem_req_valid=0. When stall_in=0: load IF/ID from buffer, PC<=PC+4 -> REQ.
- No instruction to deliver and stall_in=0: next edge if_id_valid_inst=0, if_id_IR=NOP_INST, PC/NPC hold.
- stall_in=1 with no redirect: all if_id_* hold their values.
- Throughput: one instruction per 2 cycles at zero memory wait.
- Redirect (ex_take_branch_in=1) has priority over stall and normal flow:
  - PC<={ex_target_PC_in[31:2],2'b00}.
  - Next edge: if_id_valid_inst=0, IR=NOP_INST, even under stall.
  - Hold buffer cleared.
  - In REQ with handshake completing the same cycle: discard<=1 -> WAIT. Without handshake: stay in REQ; new address presented next cycle.
  - In WAIT: if resp_valid arrives the same cycle, drop it -> REQ. Otherwise discard<=1, stay WAIT.
  - In HOLD: -> REQ.
- Back-to-back redirects: the last one wins; discard never exceeds one outstanding response.
- resp_valid outside WAIT is ignored, including stale responses after a mid-flight reset.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 wraps to 0.

Test Plan:
- Reset, req_ready=1, 1-cycle response latency, data = addr^0xA5A5_0000 -> requests at 0x0, 0x4, 0x8 on alternate cycles; IF/ID shows PC 0x0/NPC 0x4/IR 0xA5A5_0000, then 0x4 with valid=1; valid=0 in gap cycles.
- Response 0x0000_1234 arrives while stall_in=1 for 3 cycles -> IF/ID unchanged during stall; HOLD entered; cycle after stall drops, IR=0x0000_1234; next request addr = that PC+4.
- Request for 0x8 accepted; redirect to 0x100 pulsed the next cycle; response arrives 2 cycles later -> response dropped, valid_inst=0, next imem_req_addr=0x100, first delivered IF/ID PC=0x100.
- Redirect to 0x103 with stall_in=1 in the same cycle -> valid_inst=0, IR=0x13 next edge; next fetch addr 0x100.
- rst asserted mid-WAIT, response arrives one cycle after rst drops -> outputs at reset values immediately (async); stale response ignored; first request addr=RESET_PC.
- PC=0xFFFF_FFFC fetched -> if_id_NPC=0x0, next request addr 0x0.
